// File: rtl/hi_ssp_pkg.sv
// Shared constants and FSM state type for the HF reader SSP I/Q serializer.
package hi_ssp_pkg;
  localparam int SSP_WORD_BITS = 16;
  localparam int CORR_WIDTH    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ssp_state_e;
endpackage

// File: rtl/ssp_bit_timer.sv
// Bit-period divider: low phase then high phase of HALF_PERIOD cycles each,
// with a strobe on the last cycle of the high phase.
module ssp_bit_timer #(
  parameter int HALF_PERIOD = 1
) (
  input  logic ck_1356meg,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic phase,
  output logic bit_end
);
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  // Idle or restart parks the divider at the start of a low phase.
  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (run && !load) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase   = phase_q;
  assign bit_end = run && phase_q && (cnt_q == CNT_LAST);
endmodule

// File: rtl/ssp_iq_serializer.sv
// Serializes one I/Q correlation pair per report as a 16-bit SSP word, MSB first,
// through a one-word holding buffer with saturating drop accounting.
module ssp_iq_serializer
  import hi_ssp_pkg::*;
#(
  parameter int HALF_PERIOD = 1,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                         ck_1356meg,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic signed [CORR_WIDTH-1:0] corr_i,
  input  logic signed [CORR_WIDTH-1:0] corr_q,
  input  logic                         corr_valid,
  output logic                         ssp_clk,
  output logic                         ssp_frame,
  output logic                         ssp_din,
  output logic                         busy,
  output logic                         overflow,
  output logic [7:0]                   drop_count
);
  localparam int BCW = $clog2(SSP_WORD_BITS);
  localparam logic [BCW-1:0] BIT_TOP = BCW'(SSP_WORD_BITS - 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ssp_state_e               state_q, state_d;
  logic [SSP_WORD_BITS-1:0] shreg_q, shreg_d;
  logic [SSP_WORD_BITS-1:0] hold_q, hold_d;
  logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]            gap_cnt_q, gap_cnt_d;
  logic                     full_q, full_d;
  logic                     frame_q, frame_d;
  logic                     din_q, din_d;
  logic                     busy_q, busy_d;
  logic                     ovf_q, ovf_d;
  logic [7:0]               drop_q, drop_d;
  logic                     load;
  logic                     bit_end;
  logic                     phase;

  ssp_bit_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .load       (load),
    .run        (state_q == SHIFT),
    .phase      (phase),
    .bit_end    (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    frame_d   = frame_q;
    din_d     = din_q;
    load      = 1'b0;
    case (state_q)
      IDLE: if (full_q) load = 1'b1;
      SHIFT: begin
        if (bit_end) begin
          frame_d = 1'b0;
          if (bit_cnt_q == '0) begin
            din_d     = 1'b0;
            bit_cnt_d = BIT_TOP;
            gap_cnt_d = '0;
            state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - BCW'(1);
            shreg_d   = {shreg_q[SSP_WORD_BITS-2:0], 1'b0};
            din_d     = shreg_q[SSP_WORD_BITS-2];
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (full_q && enable) load = 1'b1;
          else state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shreg_d   = hold_q;
      din_d     = hold_q[SSP_WORD_BITS-1];
      frame_d   = 1'b1;
      bit_cnt_d = BIT_TOP;
      state_d   = SHIFT;
    end
    busy_d = (state_d != IDLE);
  end

  // A pair arriving on the drain edge refills the buffer; with enable low the buffer empties silently.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    ovf_d  = 1'b0;
    drop_d = drop_q;
    if (load || !enable) full_d = 1'b0;
    if (corr_valid && enable) begin
      if (!full_q || load) begin
        hold_d = {corr_i, corr_q};
        full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      hold_q    <= '0;
      bit_cnt_q <= BIT_TOP;
      gap_cnt_q <= '0;
      full_q    <= 1'b0;
      frame_q   <= 1'b0;
      din_q     <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      full_q    <= full_d;
      frame_q   <= frame_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  assign ssp_clk    = phase;
  assign ssp_frame  = frame_q;
  assign ssp_din    = din_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
endmodule
